// File: rtl/riscv_mem_responder_pkg.sv
// riscv_mem_responder_pkg: shared constants and FSM encoding for the riscv memory responder
package riscv_mem_responder_pkg;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0033;
  localparam logic [31:0] TOHOST_DEFAULT = 32'hFFFF_FFFC;
  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;
endpackage

// File: rtl/riscv_mem_responder_word_ram.sv
// riscv_word_ram: word memory with one synchronous write port and one asynchronous read port
module riscv_word_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  // write lands at the edge; contents survive reset so a reloaded program sees old data
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: loads, runs and halts the riscv core while serving its fetch and data ports
module riscv_mem_responder
  import riscv_mem_responder_pkg::*;
#(
  parameter int                   BUS_WIDTH   = 32,
  parameter int                   IMEM_WORDS  = 256,
  parameter int                   DMEM_WORDS  = 256,
  parameter logic [BUS_WIDTH-1:0] TOHOST_ADDR = BUS_WIDTH'(TOHOST_DEFAULT),
  parameter int                   CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 cpu_reset,
  input  logic [BUS_WIDTH-1:0] iaddr,
  output logic [BUS_WIDTH-1:0] idata,
  input  logic                 iwr,
  input  logic [BUS_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0] data_out,
  input  logic                 wr,
  input  logic                 re,
  output logic [BUS_WIDTH-1:0] data_in,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [BUS_WIDTH-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] tohost,
  output logic                 err_oob,
  output logic                 err_misalign,
  output logic                 err_proto,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  state_t               r_state, w_next;
  logic [IAW-1:0]       r_ld_ptr;
  logic                 r_ld_ready, r_cpu_reset;
  logic [BUS_WIDTH-1:0] r_tohost;
  logic                 r_oob, r_mis, r_pro;
  logic [CNT_WIDTH-1:0] r_rd, r_wr;
  logic [BUS_WIDTH-1:0] w_ird, w_drd;
  logic w_run, w_ld_fire, w_ld_end, w_ld, w_st, w_host, w_mis, w_oob, w_ok;
  logic w_ld_done, w_st_done, w_dwe, w_halt, w_unused;

  assign w_run     = r_state == S_RUN;
  assign w_ld_fire = r_state == S_LOAD && ld_valid && r_ld_ready;
  assign w_ld_end  = w_ld_fire && (ld_last || r_ld_ptr == IAW'(IMEM_WORDS - 1));
  assign w_ld      = w_run && re && !wr && !iwr;
  assign w_st      = w_run && wr && !re && !iwr;
  assign w_host    = addr == TOHOST_ADDR;
  assign w_mis     = addr[1:0] != 2'b00;
  assign w_oob     = addr >= BUS_WIDTH'(DMEM_WORDS * 4);
  assign w_ok      = !w_mis && !w_oob;
  assign w_ld_done = w_ld && (w_host || w_ok);
  assign w_st_done = w_st && (w_host || w_ok);
  assign w_dwe     = w_st && !w_host && w_ok;
  assign w_halt    = w_st && w_host;
  assign w_unused  = &{1'b0, iaddr[1:0]};

  riscv_word_ram #(.DEPTH(IMEM_WORDS), .WIDTH(BUS_WIDTH)) u_imem (
    .clk     (clk),
    .i_we    (w_ld_fire),
    .i_waddr (r_ld_ptr),
    .i_wdata (ld_data),
    .i_raddr (iaddr[IAW+1:2]),
    .o_rdata (w_ird)
  );

  riscv_word_ram #(.DEPTH(DMEM_WORDS), .WIDTH(BUS_WIDTH)) u_dmem (
    .clk     (clk),
    .i_we    (w_dwe),
    .i_waddr (addr[DAW+1:2]),
    .i_wdata (data_out),
    .i_raddr (addr[DAW+1:2]),
    .o_rdata (w_drd)
  );

  // state register
  always_ff @(posedge clk)
    r_state <= reset ? S_LOAD : w_next;

  // next state: the TOHOST store halts, the final loader word starts the core
  always_comb begin
    w_next = r_state;
    w_next = w_halt ? S_HALT : (r_state == S_LOAD && w_ld_end) ? S_RUN : r_state;
  end

  // loader pointer, handshake and core reset, all registered off the next state
  always_ff @(posedge clk) begin
    r_ld_ptr    <= reset ? '0 : w_ld_fire ? r_ld_ptr + IAW'(1) : r_ld_ptr;
    r_ld_ready  <= !reset && w_next == S_LOAD;
    r_cpu_reset <= reset || w_next != S_RUN;
  end

  // mailbox, sticky error flags and saturating access counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tohost <= '0;
      r_oob    <= 1'b0;
      r_mis    <= 1'b0;
      r_pro    <= 1'b0;
      r_rd     <= '0;
      r_wr     <= '0;
    end else begin
      if (w_halt) r_tohost <= data_out;
      if ((w_ld || w_st) && !w_host && w_oob) r_oob <= 1'b1;
      if ((w_ld || w_st) && !w_host && w_mis) r_mis <= 1'b1;
      if (w_run && ((wr && re) || iwr)) r_pro <= 1'b1;
      if (w_ld_done && r_rd != '1) r_rd <= r_rd + CNT_WIDTH'(1);
      if (w_st_done && r_wr != '1) r_wr <= r_wr + CNT_WIDTH'(1);
    end
  end

  assign idata        = (w_run && iaddr < BUS_WIDTH'(IMEM_WORDS * 4)) ? w_ird : BUS_WIDTH'(NOP_INSTR);
  assign data_in      = w_ld ? (w_host ? r_tohost : w_ok ? w_drd : '0) : '0;
  assign cpu_reset    = r_cpu_reset;
  assign ld_ready     = r_ld_ready;
  assign done         = r_state == S_HALT;
  assign tohost       = r_tohost;
  assign err_oob      = r_oob;
  assign err_misalign = r_mis;
  assign err_proto    = r_pro;
  assign rd_count     = r_rd;
  assign wr_count     = r_wr;
endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb_riscv_mem_responder: randomized run of the memory responder against a behavioural model
module tb_riscv_mem_responder;
  localparam logic [31:0] NOP = 32'h0000_0033;
  localparam logic [31:0] TOH = 32'hFFFF_FFFC;
  logic clk = 0, reset = 1, iwr = 0, wr = 0, re = 0, ld_valid = 0, ld_last = 0;
  logic [31:0] iaddr = 0, addr = 0, data_out = 0, ld_data = 0;
  logic cpu_reset, ld_ready, done, err_oob, err_misalign, err_proto;
  logic [31:0] idata, data_in, tohost;
  logic [15:0] rd_count, wr_count;
  int n_chk = 0, n_err = 0;
  logic [31:0] im [256];
  logic [31:0] dm [256];
  logic [31:0] m_host;
  int ph, ptr, m_rd, m_wr;
  bit m_oob, m_mis, m_pro;

  riscv_mem_responder dut (
    .clk(clk), .reset(reset), .cpu_reset(cpu_reset), .iaddr(iaddr), .idata(idata), .iwr(iwr),
    .addr(addr), .data_out(data_out), .wr(wr), .re(re), .data_in(data_in),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .done(done), .tohost(tohost), .err_oob(err_oob), .err_misalign(err_misalign),
    .err_proto(err_proto), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state;
    check("cpu_reset", 32'(cpu_reset), 32'(ph != 1));
    check("done", 32'(done), 32'(ph == 2));
    check("tohost", tohost, m_host);
    check("err_oob", 32'(err_oob), 32'(m_oob));
    check("err_misalign", 32'(err_misalign), 32'(m_mis));
    check("err_proto", 32'(err_proto), 32'(m_pro));
    check("rd_count", 32'(rd_count), 32'(m_rd));
    check("wr_count", 32'(wr_count), 32'(m_wr));
  endtask

  task automatic do_reset;
    reset = 1; ld_valid = 0; re = 0; wr = 0; iwr = 0;
    cyc;
    cyc;
    reset = 0;
    ph = 0; ptr = 0; m_rd = 0; m_wr = 0; m_oob = 0; m_mis = 0; m_pro = 0; m_host = 0;
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_idata", idata, NOP);
    check("rst_data_in", data_in, 32'd0);
    chk_state;
  endtask

  task automatic push(input logic [31:0] d, input bit last);
    int k = 0;
    ld_valid = 1; ld_data = d; ld_last = last;
    while (!ld_ready && k < 20) begin
      cyc;
      k++;
    end
    check("ld_ready", 32'(ld_ready), 32'd1);
    check("load_idata", idata, NOP);
    cyc;
    ld_valid = 0; ld_last = 0;
    im[ptr[7:0]] = d;
    ptr++;
    if (last || ptr == 256) ph = 1;
    chk_state;
    check("ld_ready_after", 32'(ld_ready), 32'(ph == 0));
  endtask

  task automatic dop(input bit r, input bit w, input bit i, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ia);
    logic [31:0] ed, ei;
    bit ok;
    re = r; wr = w; iwr = i; addr = a; data_out = d; iaddr = ia;
    ok = a[1:0] == 2'b00 && a < 1024;
    ed = 0;
    if (ph == 1 && r && !w && !i) ed = (a == TOH) ? m_host : ok ? dm[a[9:2]] : 32'd0;
    ei = (ph == 1 && ia < 1024) ? im[ia[9:2]] : NOP;
    #1;
    check("data_in", data_in, ed);
    check("idata", idata, ei);
    cyc;
    if (ph == 1) begin
      if (i || (r && w)) m_pro = 1;
      else if (r || w) begin
        if (a == TOH) begin
          if (w) begin m_host = d; ph = 2; m_wr++; end
          else m_rd++;
        end else begin
          if (a[1:0] != 2'b00) m_mis = 1;
          if (a >= 1024) m_oob = 1;
          if (ok) begin
            if (w) begin dm[a[9:2]] = d; m_wr++; end
            else m_rd++;
          end
        end
      end
    end
    re = 0; wr = 0; iwr = 0;
    chk_state;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    do_reset;
    for (int k = 0; k < 256; k++) begin
      logic [31:0] v;
      v = (k == 3) ? NOP : $urandom;
      push(v, 1'b0);
    end
    ld_valid = 1; ld_data = 32'h1234_5678;
    dop(0, 0, 0, 0, 0, 0);
    dop(0, 0, 0, 0, 0, 4);
    ld_valid = 0;
    check("stream_ld_ready", 32'(ld_ready), 32'd0);

    do_reset;
    push($urandom, 1'b0);
    push($urandom, 1'b0);
    do_reset;
    push(32'h0050_0093, 1'b0);
    push(32'h00A0_0113, 1'b0);
    push(32'h0020_81B3, 1'b1);
    dop(0, 0, 0, 0, 0, 8);
    check("fetch8", idata, 32'h0020_81B3);
    dop(0, 0, 0, 0, 0, 12);
    dop(0, 0, 0, 0, 0, 0);
    dop(0, 0, 0, 0, 0, 1024);

    dop(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 0);
    dop(1, 0, 0, 32'h10, 0, 4);
    check("wr_count1", 32'(wr_count), 32'd1);
    check("rd_count1", 32'(rd_count), 32'd1);

    for (int k = 0; k < 16; k++) dop(0, 1, 0, k * 4, $urandom, k * 4);
    dop(0, 1, 0, 1020, $urandom, 0);
    for (int n = 0; n < 400; n++) begin
      int op, sel;
      logic [31:0] a;
      bit r, w, i;
      op  = $urandom_range(0, 11);
      sel = $urandom_range(0, 9);
      i = op == 9;
      r = op < 4 || op == 8 || (i && $urandom_range(0, 1) == 1);
      w = (op >= 4 && op < 8) || op == 8 || (i && $urandom_range(0, 1) == 1);
      a = sel < 6 ? $urandom_range(0, 15) * 4 :
          sel == 6 ? (($urandom_range(0, 15) * 4) | $urandom_range(1, 3)) :
          sel == 7 ? 1024 + $urandom_range(0, 4000) * 4 :
          sel == 8 ? TOH : 32'd1020;
      if (a == TOH) w = 0;
      dop(r, w, i, a, $urandom, $urandom_range(0, 1100));
    end

    dop(1, 0, 0, 32'h12, 0, 0);
    check("misalign_set", 32'(err_misalign), 32'd1);
    dop(1, 0, 0, 1024, 0, 0);
    check("oob_set", 32'(err_oob), 32'd1);
    dop(1, 1, 0, 32'h14, 32'h55AA_55AA, 0);
    check("proto_set", 32'(err_proto), 32'd1);
    dop(1, 0, 0, 32'h14, 0, 0);
    dop(1, 0, 0, 32'h18, 0, 0);
    dop(0, 1, 0, 32'h18, 32'hCAFE_F00D, 0);
    dop(1, 0, 0, 32'h18, 0, 0);
    dop(1, 0, 0, TOH, 0, 0);

    dop(0, 1, 0, TOH, 32'h1, 0);
    check("halt_tohost", tohost, 32'h1);
    check("halt_done", 32'(done), 32'd1);
    dop(0, 1, 0, 32'h10, 32'h0BAD_C0DE, 0);
    dop(1, 0, 0, 32'h10, 0, 0);
    check("halt_ld_ready", 32'(ld_ready), 32'd0);

    do_reset;
    push(NOP, 1'b1);
    dop(1, 0, 0, 32'h10, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
